// File: rtl/multicycle_control_unit.sv
// ============================================================================
// multicycle_control_unit : Moore FSM sequencing the multicycle MIPS datapath
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_control_unit #(
  parameter int ALUCTRL_W   = 3,
  parameter int SUPPORT_BNE = 1,
  parameter int MEM_WAIT    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pcen,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal_op,
  output logic [3:0]           state_o
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_J     = 6'b000010;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_BNE   = 6'b000101;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;

  localparam logic [2:0] C_ALU_AND = 3'b000;
  localparam logic [2:0] C_ALU_OR  = 3'b001;
  localparam logic [2:0] C_ALU_ADD = 3'b010;
  localparam logic [2:0] C_ALU_SUB = 3'b110;
  localparam logic [2:0] C_ALU_SLT = 3'b111;

  localparam logic C_BNE_EN   = (SUPPORT_BNE != 0);
  localparam logic C_WAIT_EN  = (MEM_WAIT != 0);

  state_t state_q;
  state_t state_d;

  logic       w_rdy;
  logic       w_is_lw;
  logic       w_is_sw;
  logic       w_is_r;
  logic       w_is_beq;
  logic       w_is_bne;
  logic       w_is_addi;
  logic       w_is_j;
  logic       w_supported;
  logic       w_pcwrite;
  logic       w_br_take;
  logic [2:0] w_alu3;
  logic [2:0] w_funct_alu;

  assign w_rdy = mem_ready | ~C_WAIT_EN;

  assign w_is_lw     = (op == C_OP_LW);
  assign w_is_sw     = (op == C_OP_SW);
  assign w_is_r      = (op == C_OP_RTYPE);
  assign w_is_beq    = (op == C_OP_BEQ);
  assign w_is_bne    = (op == C_OP_BNE) & C_BNE_EN;
  assign w_is_addi   = (op == C_OP_ADDI);
  assign w_is_j      = (op == C_OP_J);
  assign w_supported = w_is_lw | w_is_sw | w_is_r | w_is_beq | w_is_bne
                     | w_is_addi | w_is_j;

  // Unknown funct codes fall back to add; the write-back still happens.
  always_comb begin
    w_funct_alu = C_ALU_ADD;
    unique case (funct)
      6'b100000: w_funct_alu = C_ALU_ADD;
      6'b100010: w_funct_alu = C_ALU_SUB;
      6'b100100: w_funct_alu = C_ALU_AND;
      6'b100101: w_funct_alu = C_ALU_OR;
      6'b101010: w_funct_alu = C_ALU_SLT;
      default:   w_funct_alu = C_ALU_ADD;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:   state_d = w_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (w_is_lw | w_is_sw)          state_d = S_MEMADR;
        else if (w_is_r)                state_d = S_EXECUTE;
        else if (w_is_beq | w_is_bne)   state_d = S_BRANCH;
        else if (w_is_addi)             state_d = S_ADDIEX;
        else if (w_is_j)                state_d = S_JUMP;
        else                            state_d = S_FETCH;
      end
      S_MEMADR:  state_d = w_is_lw ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = w_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = w_rdy ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    w_pcwrite  = 1'b0;
    w_br_take  = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    w_alu3     = C_ALU_AND;
    illegal_op = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        alusrcb   = 2'b01;
        w_alu3    = C_ALU_ADD;
        irwrite   = w_rdy;
        w_pcwrite = w_rdy;
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        w_alu3     = C_ALU_ADD;
        illegal_op = ~w_supported;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_alu3  = C_ALU_ADD;
      end
      S_MEMRD: begin
        iord = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        w_alu3  = w_funct_alu;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        // IR is stable here, so op still selects beq versus bne.
        alusrca   = 1'b1;
        w_alu3    = C_ALU_SUB;
        pcsrc     = 2'b01;
        w_br_take = w_is_bne ? ~zero : zero;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_alu3  = C_ALU_ADD;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
      end
      S_JUMP: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: begin
        w_pcwrite = 1'b0;
      end
    endcase
  end

  assign pcen    = w_pcwrite | w_br_take;
  assign state_o = state_q;

  generate
    if (ALUCTRL_W > 3) begin : g_alu_pad
      assign alucontrol = {{(ALUCTRL_W-3){1'b0}}, w_alu3};
    end else begin : g_alu_nopad
      assign alucontrol = w_alu3[ALUCTRL_W-1:0];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ============================================================================
// tb_multicycle_control_unit : scoreboard bench for the multicycle control FSM
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control_unit;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct packed {
    logic [3:0] st;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluc;
    logic       ill;
  } outv_t;

  typedef struct {
    string      name;
    outv_t      v;
    logic       chk1;
    logic [3:0] s1;
    logic       i1;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal_op;
  logic [3:0] state_o;

  logic       pcen1, iord1, memwrite1, irwrite1, regdst1, memtoreg1, regwrite1, alusrca1;
  logic [1:0] alusrcb1, pcsrc1;
  logic [2:0] alucontrol1;
  logic       illegal_op1;
  logic [3:0] state_o1;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic u1_sync = 1'b1;

  multicycle_control_unit #(.ALUCTRL_W(3), .SUPPORT_BNE(1), .MEM_WAIT(1)) u_dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pcen(pcen), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .illegal_op(illegal_op), .state_o(state_o)
  );

  multicycle_control_unit #(.ALUCTRL_W(3), .SUPPORT_BNE(0), .MEM_WAIT(1)) u_nobne (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pcen(pcen1), .iord(iord1), .memwrite(memwrite1),
    .irwrite(irwrite1), .regdst(regdst1), .memtoreg(memtoreg1),
    .regwrite(regwrite1), .alusrca(alusrca1), .alusrcb(alusrcb1), .pcsrc(pcsrc1),
    .alucontrol(alucontrol1), .illegal_op(illegal_op1), .state_o(state_o1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vectors, one per state, from the state table.
  function automatic outv_t e_st(input logic [3:0] s);
    outv_t v;
    v = '0;
    v.st = s;
    return v;
  endfunction
  function automatic outv_t e_fetch(input logic r);
    outv_t v;
    v = e_st(4'd0); v.alusrcb = 2'b01; v.aluc = 3'b010; v.irwrite = r; v.pcen = r;
    return v;
  endfunction
  function automatic outv_t e_dec(input logic ill);
    outv_t v;
    v = e_st(4'd1); v.alusrcb = 2'b11; v.aluc = 3'b010; v.ill = ill;
    return v;
  endfunction
  function automatic outv_t e_memadr();
    outv_t v;
    v = e_st(4'd2); v.alusrca = 1'b1; v.alusrcb = 2'b10; v.aluc = 3'b010;
    return v;
  endfunction
  function automatic outv_t e_memrd();
    outv_t v;
    v = e_st(4'd3); v.iord = 1'b1;
    return v;
  endfunction
  function automatic outv_t e_memwb();
    outv_t v;
    v = e_st(4'd4); v.memtoreg = 1'b1; v.regwrite = 1'b1;
    return v;
  endfunction
  function automatic outv_t e_memwr();
    outv_t v;
    v = e_st(4'd5); v.iord = 1'b1; v.memwrite = 1'b1;
    return v;
  endfunction
  function automatic outv_t e_exec(input logic [2:0] a);
    outv_t v;
    v = e_st(4'd6); v.alusrca = 1'b1; v.aluc = a;
    return v;
  endfunction
  function automatic outv_t e_aluwb();
    outv_t v;
    v = e_st(4'd7); v.regdst = 1'b1; v.regwrite = 1'b1;
    return v;
  endfunction
  function automatic outv_t e_branch(input logic p);
    outv_t v;
    v = e_st(4'd8); v.alusrca = 1'b1; v.aluc = 3'b110; v.pcsrc = 2'b01; v.pcen = p;
    return v;
  endfunction
  function automatic outv_t e_addiex();
    outv_t v;
    v = e_st(4'd9); v.alusrca = 1'b1; v.alusrcb = 2'b10; v.aluc = 3'b010;
    return v;
  endfunction
  function automatic outv_t e_addiwb();
    outv_t v;
    v = e_st(4'd10); v.regwrite = 1'b1;
    return v;
  endfunction
  function automatic outv_t e_jump();
    outv_t v;
    v = e_st(4'd11); v.pcsrc = 2'b10; v.pcen = 1'b1;
    return v;
  endfunction

  task automatic cyb(input string nm, input logic [5:0] o, input logic [5:0] f,
                     input logic zr, input logic mr, input logic rs, input outv_t e,
                     input logic c1, input logic [3:0] s1, input logic i1);
    exp_t x;
    op = o; funct = f; zero = zr; mem_ready = mr; reset = rs;
    x.name = nm; x.v = e; x.chk1 = c1; x.s1 = s1; x.i1 = i1;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic cy(input string nm, input logic [5:0] o, input logic [5:0] f,
                    input logic zr, input logic mr, input logic rs, input outv_t e);
    cyb(nm, o, f, zr, mr, rs, e, u1_sync, e.st, e.ill);
  endtask

  // Monitor: every cycle the DUT presents outputs; compare against the queue head.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t  x;
      outv_t act;
      x = sb.pop_front();
      act = {state_o, pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
             alusrca, alusrcb, pcsrc, alucontrol, illegal_op};
      checks++;
      if (act !== x.v) begin
        errors++;
        $display("FAIL %s: got st=%0d pcen=%b iord=%b mw=%b irw=%b rd=%b m2r=%b rw=%b sa=%b sb=%b ps=%b alu=%b ill=%b, want st=%0d pcen=%b iord=%b mw=%b irw=%b rd=%b m2r=%b rw=%b sa=%b sb=%b ps=%b alu=%b ill=%b",
                 x.name, act.st, act.pcen, act.iord, act.memwrite, act.irwrite,
                 act.regdst, act.memtoreg, act.regwrite, act.alusrca, act.alusrcb,
                 act.pcsrc, act.aluc, act.ill, x.v.st, x.v.pcen, x.v.iord,
                 x.v.memwrite, x.v.irwrite, x.v.regdst, x.v.memtoreg, x.v.regwrite,
                 x.v.alusrca, x.v.alusrcb, x.v.pcsrc, x.v.aluc, x.v.ill);
      end
      if (x.chk1) begin
        checks++;
        if ({state_o1, illegal_op1} !== {x.s1, x.i1}) begin
          errors++;
          $display("FAIL %s/nobne: got st=%0d ill=%b, want st=%0d ill=%b",
                   x.name, state_o1, illegal_op1, x.s1, x.i1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  localparam logic [5:0] FUNCTS [4] = '{6'b100000, 6'b100100, 6'b100101, 6'b101010};
  localparam logic [2:0] ALUS   [4] = '{3'b010, 3'b000, 3'b001, 3'b111};

  initial begin
    reset = 1'b1; op = OP_R; funct = 6'b0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    cy("rst_hold", OP_R, 6'd0, 0, 1, 1, e_fetch(1));

    cy("lw_fetch", OP_LW, 6'd0, 0, 1, 0, e_fetch(1));
    cy("lw_dec",   OP_LW, 6'd0, 0, 1, 0, e_dec(0));
    cy("lw_adr",   OP_LW, 6'd0, 0, 1, 0, e_memadr());
    cy("lw_rd",    OP_LW, 6'd0, 0, 1, 0, e_memrd());
    cy("lw_wb",    OP_LW, 6'd0, 0, 1, 0, e_memwb());

    cy("sub_fetch", OP_R, 6'b100010, 0, 1, 0, e_fetch(1));
    cy("sub_dec",   OP_R, 6'b100010, 0, 1, 0, e_dec(0));
    cy("sub_exec",  OP_R, 6'b100010, 0, 1, 0, e_exec(3'b110));
    cy("sub_wb",    OP_R, 6'b100010, 0, 1, 0, e_aluwb());

    for (int i = 0; i < 4; i++) begin
      cy("r_fetch", OP_R, FUNCTS[i], 0, 1, 0, e_fetch(1));
      cy("r_dec",   OP_R, FUNCTS[i], 0, 1, 0, e_dec(0));
      cy("r_exec",  OP_R, FUNCTS[i], 0, 1, 0, e_exec(ALUS[i]));
      cy("r_wb",    OP_R, FUNCTS[i], 0, 1, 0, e_aluwb());
    end

    cy("rbad_fetch", OP_R, 6'b111111, 0, 1, 0, e_fetch(1));
    cy("rbad_dec",   OP_R, 6'b111111, 0, 1, 0, e_dec(0));
    cy("rbad_exec",  OP_R, 6'b111111, 0, 1, 0, e_exec(3'b010));
    cy("rbad_wb",    OP_R, 6'b111111, 0, 1, 0, e_aluwb());

    cy("addi_fetch", OP_ADDI, 6'd0, 0, 1, 0, e_fetch(1));
    cy("addi_dec",   OP_ADDI, 6'd0, 0, 1, 0, e_dec(0));
    cy("addi_ex",    OP_ADDI, 6'd0, 0, 1, 0, e_addiex());
    cy("addi_wb",    OP_ADDI, 6'd0, 0, 1, 0, e_addiwb());

    cy("j_fetch", OP_J, 6'd0, 0, 1, 0, e_fetch(1));
    cy("j_dec",   OP_J, 6'd0, 0, 1, 0, e_dec(0));
    cy("j_jump",  OP_J, 6'd0, 0, 1, 0, e_jump());

    cy("beq1_fetch", OP_BEQ, 6'd0, 1, 1, 0, e_fetch(1));
    cy("beq1_dec",   OP_BEQ, 6'd0, 1, 1, 0, e_dec(0));
    cy("beq1_br",    OP_BEQ, 6'd0, 1, 1, 0, e_branch(1));
    cy("beq0_fetch", OP_BEQ, 6'd0, 0, 1, 0, e_fetch(1));
    cy("beq0_dec",   OP_BEQ, 6'd0, 0, 1, 0, e_dec(0));
    cy("beq0_br",    OP_BEQ, 6'd0, 0, 1, 0, e_branch(0));

    cy("sw_fetch", OP_SW, 6'd0, 0, 1, 0, e_fetch(1));
    cy("sw_dec",   OP_SW, 6'd0, 0, 1, 0, e_dec(0));
    cy("sw_adr",   OP_SW, 6'd0, 0, 1, 0, e_memadr());
    for (int i = 0; i < 3; i++) cy("sw_wait", OP_SW, 6'd0, 0, 0, 0, e_memwr());
    cy("sw_done",  OP_SW, 6'd0, 0, 1, 0, e_memwr());

    cy("lwwt_fwait", OP_LW, 6'd0, 0, 0, 0, e_fetch(0));
    cy("lwwt_fetch", OP_LW, 6'd0, 0, 1, 0, e_fetch(1));
    cy("lwwt_dec",   OP_LW, 6'd0, 0, 1, 0, e_dec(0));
    cy("lwwt_adr",   OP_LW, 6'd0, 0, 1, 0, e_memadr());
    cy("lwwt_rwait", OP_LW, 6'd0, 0, 0, 0, e_memrd());
    cy("lwwt_rd",    OP_LW, 6'd0, 0, 1, 0, e_memrd());
    cy("lwwt_wb",    OP_LW, 6'd0, 0, 1, 0, e_memwb());

    cy("ill_fetch", OP_BAD, 6'd0, 0, 1, 0, e_fetch(1));
    cy("ill_dec",   OP_BAD, 6'd0, 0, 1, 0, e_dec(1));

    // bne: the no-bne instance flags illegal and drifts one state apart.
    cy("bne1_fetch", OP_BNE, 6'd0, 1, 1, 0, e_fetch(1));
    cyb("bne1_dec",  OP_BNE, 6'd0, 1, 1, 0, e_dec(0), 1'b1, 4'd1, 1'b1);
    cyb("bne1_br",   OP_BNE, 6'd0, 1, 1, 0, e_branch(0), 1'b1, 4'd0, 1'b0);
    cyb("bne1_rsync", OP_R, 6'd0, 0, 1, 1, e_fetch(1), 1'b0, 4'd0, 1'b0);
    cy("bne0_fetch", OP_BNE, 6'd0, 0, 1, 0, e_fetch(1));
    cyb("bne0_dec",  OP_BNE, 6'd0, 0, 1, 0, e_dec(0), 1'b1, 4'd1, 1'b1);
    cyb("bne0_br",   OP_BNE, 6'd0, 0, 1, 0, e_branch(1), 1'b1, 4'd0, 1'b0);
    cyb("bne0_rsync", OP_R, 6'd0, 0, 1, 1, e_fetch(1), 1'b0, 4'd0, 1'b0);

    cy("rmid_fetch", OP_LW, 6'd0, 0, 1, 0, e_fetch(1));
    cy("rmid_dec",   OP_LW, 6'd0, 0, 1, 0, e_dec(0));
    cy("rmid_adr",   OP_LW, 6'd0, 0, 1, 0, e_memadr());
    cy("rmid_rd",    OP_LW, 6'd0, 0, 0, 1, e_memrd());
    cy("rmid_after", OP_LW, 6'd0, 0, 1, 0, e_fetch(1));
    cy("rmid_dec2",  OP_LW, 6'd0, 0, 1, 0, e_dec(0));

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Control unit for the multicycle MIPS datapath. It replaces the single-cycle decoder pair with a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles. It adds memory wait-state handling, optional bne support and an illegal-opcode flag. It drives the shared-memory multicycle datapath (IR, A/B, ALUOut and Data registers live in the datapath).

Parameters:
ALUCTRL_W, 3, width of alucontrol; encodings use the low 3 bits, upper bits driven 0.
SUPPORT_BNE, 1, 1 = opcode 000101 (bne) is decoded; 0 = bne is treated as illegal.
MEM_WAIT, 1, 1 = memory states wait on mem_ready; 0 = mem_ready is ignored (treated as 1).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
op  in  6  instruction[31:26] from IR
funct  in  6  instruction[5:0] from IR
zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
pcen  out  1  PC register write enable
iord  out  1  0 = memory address from PC, 1 = from ALUOut
memwrite  out  1  memory write strobe
irwrite  out  1  IR load enable
regdst  out  1  1 = rd, 0 = rt
memtoreg  out  1  1 = Data register, 0 = ALUOut
regwrite  out  1  register file write enable
alusrca  out  1  0 = PC, 1 = A
alusrcb  out  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
pcsrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
alucontrol  out  ALUCTRL_W  ALU operation
illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode
state_o  out  4  current state encoding, for debug

Behaviour:
- FSM states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. All other encodings go to FETCH.
- Reset: on a clk edge with reset=1, state goes to FETCH. This applies mid-instruction with no partial writeback.
- Outputs are combinational from state. In-state qualifiers are mem_ready and zero. Every output is 0 unless listed. During reset, state is FETCH, so outputs are FETCH values.
- FETCH: alusrcb=01, aluop=add, irwrite=pcwrite=rdy. Advance to DECODE when rdy, otherwise hold.
- DECODE: alusrcb=11, aluop=add. Next state by op:
  - lw/sw (100011/101011) -> MEMADR
  - R-type (000000) -> EXECUTE
  - beq (000100), or bne (000101) when SUPPORT_BNE -> BRANCH
  - addi (001000) -> ADDIEX
  - j (000010) -> JUMP
  - anything else -> FETCH with illegal_op=1 (acts as a NOP)
- MEMADR: alusrca=1, alusrcb=10, add. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. When rdy go to MEMWB, otherwise hold.
- MEMWB: memtoreg=1, regwrite=1, regdst=0. Go to FETCH.
- MEMWR: iord=1, memwrite=1, held through wait cycles. When rdy go to FETCH.
- EXECUTE: alusrca=1, alusrcb=00, aluop=funct. Go to ALUWB.
- ALUWB: regdst=1, regwrite=1. Go to FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01. pcen = zero for beq, ~zero for bne. Go to FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add. Go to ADDIWB.
- ADDIWB: regdst=0, regwrite=1. Go to FETCH.
- JUMP: pcsrc=10, pcen=1. Go to FETCH.
- rdy = mem_ready | ~MEM_WAIT.
- pcen = pcwrite | (branch-condition met in BRANCH).
- Branch type (beq vs bne) is taken from op while in BRANCH, because IR is stable.
- alucontrol:
  - add = 010, sub = 110
  - funct decode: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111
  - unknown funct → 010, and regwrite is still asserted in ALUWB
- Latency with no wait states: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal 2 cycles.
- Each wait cycle (rdy=0) in FETCH, MEMRD or MEMWR adds exactly one cycle. No enables other than memwrite/iord fire during waits.

Test Plan:
- Reset high 2 cycles, then release with mem_ready=1. Required: state_o=0, irwrite=1, pcen=1, alusrcb=01, alucontrol=010 in the first cycle; in the next cycle state_o=1.
- lw (op=100011), mem_ready=1. Required: states 0,1,2,3,4,0; iord=1 in MEMRD; regwrite=memtoreg=1, regdst=0 only in MEMWB.
- R-type sub (funct=100010). Required: EXECUTE alucontrol=110, alusrca=1, alusrcb=00; ALUWB regwrite=1, regdst=1; 4 cycles total.
- beq with zero=1, then bne with zero=1 (SUPPORT_BNE=1). Required: pcen=1 in BRANCH for beq, 0 for bne; pcsrc=01, alucontrol=110; back in FETCH next cycle. With SUPPORT_BNE=0, bne pulses illegal_op and returns to FETCH.
- sw with mem_ready held low 3 cycles in MEMWR. Required: memwrite=1 and iord=1 for 4 cycles, state_o=5 held, then FETCH. A FETCH wait also holds with irwrite=pcen=0.
- Illegal op=111111. Required: illegal_op=1 for one cycle in DECODE, no regwrite/memwrite, back in FETCH. Assert reset during MEMRD: required state_o=0 on the next edge with no regwrite.
